// File: rtl/aes_pkg.sv
// AES shared definitions: block/column widths, FSM state encoding and the
// forward/inverse S-box lookup functions used by sub_bytes_iter.
// Optional feature macro: SUB_BYTES_INV_EN (inverse S-box select in sbox).
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_COL_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Row-major FIPS-197 forward table, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [10:0] idx;
    idx = 11'd2047 - {x, 3'b000};
    return SBOX_FWD_TBL[idx -: 8];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    logic [10:0] idx;
    idx = 11'd2047 - {x, 3'b000};
    return SBOX_INV_TBL[idx -: 8];
  endfunction

endpackage

// File: rtl/sub_bytes_iter_sbox.sv
// Single-byte AES S-box, purely combinational.
// With SUB_BYTES_INV_EN defined, iInv=1 selects the inverse table.
module sbox
  import aes_pkg::*;
(
`ifdef SUB_BYTES_INV_EN
  input  logic       iInv,
`endif
  input  logic [7:0] iByte,
  output logic [7:0] oByte
);

`ifdef SUB_BYTES_INV_EN
  assign oByte = iInv ? sbox_inv(iByte) : sbox_fwd(iByte);
`else
  assign oByte = sbox_fwd(iByte);
`endif

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: one 32-bit column per cycle through four shared
// S-boxes, valid/ready handshake on both sides, one block per 5 cycles peak.
// Optional feature macro: SUB_BYTES_INV_EN (adds iInv, inverse S-box select).
module sub_bytes_iter
  import aes_pkg::*;
(
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [AES_BLOCK_W-1:0] iData,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [AES_BLOCK_W-1:0] oData,
  output logic                   oBusy
`ifdef SUB_BYTES_INV_EN
  , input logic                  iInv
`endif
);

  state_t                 r_state;
  logic [1:0]             r_cnt;
  logic [AES_BLOCK_W-1:0] r_data;
  logic                   r_valid;
  logic                   r_busy;
`ifdef SUB_BYTES_INV_EN
  logic                   r_inv;
`endif

  logic [AES_COL_W-1:0]   w_col;
  logic [AES_COL_W-1:0]   w_sub;
  logic [AES_BLOCK_W-1:0] w_next;
  logic                   w_accept;

  // Ready is a pure decode of state and downstream ready, forced low in reset.
  assign oReady   = !iRst && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && iReady));
  assign w_accept = iValid && oReady;
  assign oValid   = r_valid;
  assign oBusy    = r_busy;
  assign oData    = r_data;

  // Pick the column addressed by the counter; column 0 is the top word.
  always_comb begin
    w_col = r_data[127:96];
    case (r_cnt)
      2'd0: w_col = r_data[127:96];
      2'd1: w_col = r_data[95:64];
      2'd2: w_col = r_data[63:32];
      2'd3: w_col = r_data[31:0];
      default: w_col = r_data[127:96];
    endcase
  end

  // Four byte lanes shared by all columns.
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sbox u_sbox (
`ifdef SUB_BYTES_INV_EN
      .iInv  (r_inv),
`endif
      .iByte (w_col[31-8*g -: 8]),
      .oByte (w_sub[31-8*g -: 8])
    );
  end

  // Write the substituted column back into its slot of the state word.
  always_comb begin
    w_next = r_data;
    case (r_cnt)
      2'd0: w_next[127:96] = w_sub;
      2'd1: w_next[95:64]  = w_sub;
      2'd2: w_next[63:32]  = w_sub;
      2'd3: w_next[31:0]   = w_sub;
      default: w_next = r_data;
    endcase
  end

  // Control FSM with registered valid/busy; accept takes priority in IDLE and DONE.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
`ifdef SUB_BYTES_INV_EN
      r_inv   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state <= ST_SUB;
      r_cnt   <= 2'd0;
      r_data  <= iData;
      r_valid <= 1'b0;
      r_busy  <= 1'b1;
`ifdef SUB_BYTES_INV_EN
      r_inv   <= iInv;
`endif
    end else begin
      case (r_state)
        ST_SUB: begin
          r_data <= w_next;
          r_cnt  <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state <= ST_DONE;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          if (iReady) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter; S-box reference computed from GF(2^8)
// inversion plus the affine map. Define SUB_BYTES_INV_EN for inverse vectors.
module tb_sub_bytes_iter;

  logic         iClk = 1'b0;
  logic         iRst;
  logic         iValid;
  logic         oReady;
  logic [127:0] iData;
  logic         oValid;
  logic         iReady;
  logic [127:0] oData;
  logic         oBusy;
`ifdef SUB_BYTES_INV_EN
  logic         iInv;
`endif

  int n_pass = 0;
  int n_chk  = 0;

  sub_bytes_iter dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iValid (iValid),
    .oReady (oReady),
    .iData  (iData),
    .oValid (oValid),
    .iReady (iReady),
    .oData  (oData),
    .oBusy  (oBusy)
`ifdef SUB_BYTES_INV_EN
    , .iInv (iInv)
`endif
  );

  always #5 iClk = ~iClk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    logic [7:0] s;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] ref_block(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = ref_sbox(d[127-8*i -: 8]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge iClk);
    #1;
  endtask

  // Offer one block, scramble inputs after accept, and time the result.
  task automatic run_block(input logic [127:0] din, input logic [127:0] exp, input string tag);
    int lat;
    iData  = din;
    iValid = 1'b1;
    iReady = 1'b1;
    check({tag, "_ready"}, {127'd0, oReady}, 128'd1);
    step();
    iValid = 1'b0;
    iData  = ~din;
    lat = 0;
    while (!oValid && lat < 12) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'd4);
    check({tag, "_data"}, oData, exp);
    step();
    check({tag, "_valid_drop"}, {127'd0, oValid}, 128'd0);
  endtask

  logic [127:0] blk [8];
  logic [127:0] exp_blk [8];
  logic [127:0] held;
  logic         stable;
  logic         seen;
  int           idx_in, idx_out, cyc, last_out;
  logic         acc;

  initial begin
    iRst   = 1'b1;
    iValid = 1'b0;
    iReady = 1'b0;
    iData  = '0;
`ifdef SUB_BYTES_INV_EN
    iInv   = 1'b0;
`endif
    step();
    step();
    // Reset state
    check("rst_valid", {127'd0, oValid}, 128'd0);
    check("rst_busy",  {127'd0, oBusy},  128'd0);
    check("rst_data",  oData, 128'd0);
    check("rst_ready", {127'd0, oReady}, 128'd0);
    iRst = 1'b0;
    #1;

    // FIPS-197 round-1 vector, accepted on the first edge after reset
    run_block(128'h193de3bea0f4e22b9ac68d2ae9f84808,
              128'hd42711aee0bf98f1b8b45de51e415230, "fips");
    run_block({16{8'h00}}, {16{8'h63}}, "zeros");
    run_block({16{8'hff}}, {16{8'h16}}, "ones");
    run_block(128'h00112233445566778899aabbccddeeff,
              ref_block(128'h00112233445566778899aabbccddeeff), "ramp");

    // Backpressure: hold in DONE for 10 cycles with a new block offered
    iReady = 1'b0;
    iData  = 128'h0123456789abcdeffedcba9876543210;
    iValid = 1'b1;
    step();
    iValid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("bp_valid_up", {127'd0, oValid}, 128'd1);
    held   = oData;
    check("bp_data", held, ref_block(128'h0123456789abcdeffedcba9876543210));
    iData  = 128'hdeadbeef00000000cafef00d12345678;
    iValid = 1'b1;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (!oValid || oData !== held || oReady) stable = 1'b0;
      step();
    end
    check("bp_stable", {127'd0, stable}, 128'd1);
    check("bp_still_valid", {127'd0, oValid}, 128'd1);
    iReady = 1'b1;
    #1;
    check("handoff_ready", {127'd0, oReady}, 128'd1);
    step();
    iValid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (oValid) seen = 1'b1;
      step();
    end
    if (oValid) seen = 1'b1;
    check("handoff_gap", {127'd0, seen}, 128'd0);
    check("handoff_busy", {127'd0, oBusy}, 128'd1);
    step();
    check("handoff_valid", {127'd0, oValid}, 128'd1);
    check("handoff_data", oData, ref_block(128'hdeadbeef00000000cafef00d12345678));
    step();

    // Reset while cnt==2 discards the block
    iData  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    iValid = 1'b1;
    step();
    iValid = 1'b0;
    step();
    step();
    iRst = 1'b1;
    step();
    check("midrst_valid", {127'd0, oValid}, 128'd0);
    check("midrst_busy",  {127'd0, oBusy},  128'd0);
    check("midrst_data",  oData, 128'd0);
    check("midrst_ready", {127'd0, oReady}, 128'd0);
    iRst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (oValid) seen = 1'b1;
    end
    check("midrst_no_valid", {127'd0, seen}, 128'd0);
    run_block(128'h193de3bea0f4e22b9ac68d2ae9f84808,
              128'hd42711aee0bf98f1b8b45de51e415230, "after_rst");

`ifdef SUB_BYTES_INV_EN
    iInv = 1'b1;
    iData = 128'hd42711aee0bf98f1b8b45de51e415230;
    iValid = 1'b1;
    step();
    iValid = 1'b0;
    iInv = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("inv_valid", {127'd0, oValid}, 128'd1);
    check("inv_fips", oData, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    step();
    iInv = 1'b1;
    run_block({16{8'h63}}, 128'd0, "inv_63");
    iInv = 1'b0;
`endif

    // Back-to-back stream of 8 random blocks
    for (int k = 0; k < 8; k++) begin
      blk[k]     = {$urandom, $urandom, $urandom, $urandom};
      exp_blk[k] = ref_block(blk[k]);
    end
    idx_in   = 0;
    idx_out  = 0;
    last_out = 0;
    iReady   = 1'b1;
    iData    = blk[0];
    iValid   = 1'b1;
    for (cyc = 1; cyc <= 80 && idx_out < 8; cyc++) begin
      acc = oReady && iValid;
      step();
      if (acc) begin
        idx_in++;
        if (idx_in < 8) iData = blk[idx_in];
        else iValid = 1'b0;
      end
      if (oValid) begin
        check($sformatf("stream_data%0d", idx_out), oData, exp_blk[idx_out]);
        if (idx_out > 0)
          check($sformatf("stream_gap%0d", idx_out), 128'(cyc - last_out), 128'd5);
        last_out = cyc;
        idx_out++;
      end
    end
    iValid = 1'b0;
    check("stream_count", 128'(idx_out), 128'd8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sub_bytes_iter.md
SUB_BYTES_ITER -- requirements
Module: sub_bytes_iter

Interface
REQ-001 The block SHALL have port iClk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port iRst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port iValid, input, 1 bit: an input block is offered on iData.
REQ-004 The block SHALL have port oReady, output, 1 bit: the block can accept an input this cycle.
REQ-005 The block SHALL have port iData, input, 128 bits: AES state, column-major, byte 0 at [127:120].
REQ-006 The block SHALL have port oValid, output, 1 bit: oData holds a finished SubBytes result.
REQ-007 The block SHALL have port iReady, input, 1 bit: the downstream ShiftRows stage accepts oData.
REQ-008 The block SHALL have port oData, output, 128 bits: substituted state, same byte ordering as iData.
REQ-009 The block SHALL have port oBusy, output, 1 bit: high in the SUB state.

Function
REQ-010 The block SHALL implement FSM states IDLE, SUB and DONE, with a 2-bit column counter cnt.
REQ-011 Accept SHALL occur when iValid && oReady on a clock edge; iData is captured into the internal state register, cnt <= 0, and the FSM moves to SUB.
REQ-012 oReady SHALL be (state==IDLE) || (state==DONE && iReady), and SHALL be 0 while iRst is high.
REQ-013 In SUB, each edge SHALL replace column cnt (cnt=0 is bits [127:96]) with its 4 S-box outputs and increment cnt.
REQ-014 When cnt==3 in SUB, the FSM SHALL move to DONE, and cnt SHALL wrap to 0.
REQ-015 oValid SHALL be 1 exactly in DONE; oData SHALL be the register value and stable while oValid && !iReady.
REQ-016 In DONE with iReady: with iValid, the FSM SHALL accept the new block and go to SUB (simultaneous handoff); without iValid, the FSM SHALL go to IDLE.
REQ-017 Latency SHALL be 4 cycles from the accepting edge to the first cycle with oValid=1; peak throughput SHALL be one block per 5 cycles.
REQ-018 Changes on iData or iValid after accept SHALL have no effect until the next accept.
REQ-019 S-box arithmetic SHALL be the FIPS-197 byte map, bytewise with no carries; four sbox instances SHALL be shared across columns.

Reset
REQ-020 On iRst the block SHALL set state=IDLE, cnt=0, oValid=0, oBusy=0 and oData=128'h0.
REQ-021 A reset asserted mid-SUB or in DONE SHALL discard the block in flight, and no oValid pulse SHALL follow.
REQ-022 The first accept SHALL be possible on the first edge after iRst deasserts.

Configuration
REQ-023 With SUB_BYTES_INV_EN defined, the block SHALL have an extra input iInv (1 bit), sampled at accept and held for that block; iInv=1 selects the inverse S-box.
REQ-024 Without SUB_BYTES_INV_EN, the block SHALL have no iInv port and SHALL implement the forward S-box only, with no inverse table logic.

Structure
REQ-025 Package aes_pkg SHALL hold the AES_BLOCK_W=128, AES_COL_W=32 and state-encoding constants, plus the forward and inverse S-box table functions.
REQ-026 A single sub-module sbox (8-bit in, 8-bit out, combinational, plus inv select under the macro) SHALL be instantiated four times.

Verification
REQ-027 A bench SHALL check: FIPS-197 App. B round 1 input 193de3bea0f4e22b9ac68d2ae9f84808 accepted with iReady=1 -> oValid 4 cycles later, oData=d42711aee0bf98f1b8b45de51e415230.
REQ-028 A bench SHALL check: all-zero input -> oData=6363...63 (16 bytes); all-FF input -> 1616...16.
REQ-029 A bench SHALL check: iReady held 0 for 10 cycles in DONE -> oValid and oData stable, oReady=0; then iReady=1 with iValid=1 -> next block accepted the same edge and oValid drops for 4 cycles.
REQ-030 A bench SHALL check: iRst pulsed when cnt==2 -> outputs return to reset values and no oValid follows; a fresh accept afterwards completes correctly.
REQ-031 A bench SHALL check, with SUB_BYTES_INV_EN and iInv=1: input d42711aee0bf98f1b8b45de51e415230 -> oData=193de3bea0f4e22b9ac68d2ae9f84808, and input 6363...63 -> all zero.
REQ-032 A bench SHALL check: back-to-back stream of 8 random blocks with iValid and iReady always 1 -> one result per 5 cycles, each matching a software model.
